// File: rtl/start_rsp_pkg.sv
// start_rsp_pkg: shared types and helpers for the start/a/b response driver.
// Holds the FSM state encoding and the delay/hold counter width helper.
package start_rsp_pkg;

  // FSM state encoding; values are fixed so traces read the same everywhere.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRIVE = 2'd2
  } state_t;

  // Default timing: a rise is answered on the very next posedge, for one posedge.
  localparam int DEFAULT_DELAY = 1;
  localparam int DEFAULT_HOLD  = 1;
  localparam int DEFAULT_CNT_W = 8;

  // Larger of the two timing parameters.
  function automatic int max_timing(input int delay, input int hold);
    return (delay > hold) ? delay : hold;
  endfunction

  // Width of the shared delay/hold down-counter: clog2(max(DELAY,HOLD))+1.
  // The extra bit keeps the width positive when both parameters are 1.
  function automatic int cnt_width(input int delay, input int hold);
    return $clog2(max_timing(delay, hold)) + 1;
  endfunction

endpackage

// File: rtl/start_rsp_driver_rise_det.sv
// rise_det: registers start and flags its rising edge.
// rise is combinational from start and the registered copy, so it is valid
// in the same cycle start first goes high. start_q resets to 0, which makes
// a start already high at reset release count as a rise on the first edge out.
module rise_det (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic rise
);

  logic start_q;

  // Previous-cycle copy of start; cleared while reset is asserted.
  always_ff @(posedge clk) begin
    if (!rst) begin
      start_q <= 1'b0;
    end else begin
      start_q <= start;
    end
  end

  assign rise = start & ~start_q;

endmodule

// File: rtl/start_rsp_driver.sv
// start_rsp_driver: answers a rising edge on start by driving a and b high
// together DELAY posedges after the rise-detect edge, for HOLD posedges.
// Rises that arrive while a response is pending or being driven are dropped
// and counted. Both counters saturate.
//
// Optional build macro: START_RSP_ASSERT_EN
//   defined   -> embedded concurrent assertions on the response contract
//   undefined -> no assertion code; datapath behaviour identical
//
// Handshake: there is no back-pressure. A request is the rising edge of start
// sampled at a posedge; it is accepted only if the FSM is IDLE at that edge,
// otherwise it is dropped. The response is a&&b high on posedges
// k+DELAY .. k+DELAY+HOLD-1 for a rise accepted at edge k.
//
// dbg_state exposes the FSM state for checkers and waveform inspection.
module start_rsp_driver
  import start_rsp_pkg::*;
#(
  parameter int DELAY = DEFAULT_DELAY,
  parameter int HOLD  = DEFAULT_HOLD,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             a,
  output logic             b,
  output logic             busy,
  output logic [CNT_W-1:0] rsp_cnt,
  output logic [CNT_W-1:0] drop_cnt,
  output state_t           dbg_state
);

  localparam int CW = cnt_width(DELAY, HOLD);

  // Reload values for the down-counter. WAIT is entered on the rise edge, so
  // it only needs DELAY-2 further edges before moving to DRIVE.
  localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD - 1);
  localparam logic [CW-1:0] DELAY_LD = (DELAY > 1) ? CW'(DELAY - 2) : '0;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            ab_q;
  logic            rise;

  rise_det u_rise_det (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .rise  (rise)
  );

  // Response FSM with registered a/b, busy and saturating counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      ab_q     <= 1'b0;
      busy     <= 1'b0;
      rsp_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (rise) begin
            busy <= 1'b1;
            if (DELAY == 1) begin
              state <= DRIVE;
              cnt   <= HOLD_LD;
              ab_q  <= 1'b1;
              if (rsp_cnt != CNT_MAX) rsp_cnt <= rsp_cnt + CNT_ONE;
            end else begin
              state <= WAIT;
              cnt   <= DELAY_LD;
              ab_q  <= 1'b0;
            end
          end else begin
            busy <= 1'b0;
            ab_q <= 1'b0;
          end
        end

        WAIT: begin
          busy <= 1'b1;
          if (rise && (drop_cnt != CNT_MAX)) drop_cnt <= drop_cnt + CNT_ONE;
          if (cnt == '0) begin
            state <= DRIVE;
            cnt   <= HOLD_LD;
            ab_q  <= 1'b1;
            if (rsp_cnt != CNT_MAX) rsp_cnt <= rsp_cnt + CNT_ONE;
          end else begin
            cnt  <= cnt - 1'b1;
            ab_q <= 1'b0;
          end
        end

        DRIVE: begin
          // A rise on the exit edge is still dropped: acceptance needs IDLE
          // at the edge itself.
          if (rise && (drop_cnt != CNT_MAX)) drop_cnt <= drop_cnt + CNT_ONE;
          if (cnt == '0) begin
            state <= IDLE;
            ab_q  <= 1'b0;
            busy  <= 1'b0;
          end else begin
            cnt  <= cnt - 1'b1;
            ab_q <= 1'b1;
            busy <= 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
          ab_q  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // a and b come from one flop so they can never diverge.
  assign a         = ab_q;
  assign b         = ab_q;
  assign dbg_state = state;

`ifdef START_RSP_ASSERT_EN
  // a and b always match.
  property p_ab_equal;
    @(posedge clk) disable iff (!rst) (a == b);
  endproperty

  // An accepted rise produces the a&&b window DELAY edges later for HOLD edges.
  property p_rsp_window;
    @(posedge clk) disable iff (!rst)
      (state == IDLE && rise) |-> ##DELAY (a && b) [*HOLD];
  endproperty

  // drop_cnt only moves because of a rise seen while busy.
  property p_drop_when_busy;
    @(posedge clk) disable iff (!rst)
      ($changed(drop_cnt) && $past(rst)) |-> $past(busy);
  endproperty

  a_ab_equal: assert property (p_ab_equal)
    $info("a_ab_equal pass at %0t", $time);
  else
    $error("a_ab_equal violated at %0t", $time);

  a_rsp_window: assert property (p_rsp_window)
    $info("a_rsp_window pass at %0t", $time);
  else
    $error("a_rsp_window violated at %0t", $time);

  a_drop_when_busy: assert property (p_drop_when_busy)
    $info("a_drop_when_busy pass at %0t", $time);
  else
    $error("a_drop_when_busy violated at %0t", $time);
`endif

endmodule

// File: tb/tb_start_rsp_driver.sv
// tb_start_rsp_driver: directed vectors for four configurations of
// start_rsp_driver. Each vector string gives, per cycle, the rst and start
// values driven before the edge and the a/busy values expected after it.
// Expected entries go into a queue; a negedge monitor pops and compares.
module tb_start_rsp_driver;
  import start_rsp_pkg::*;

  // Entry layout: [20] kind (0 outputs, 1 counters), [19:18] instance,
  // [17] a, [16] busy, [15:8] rsp_cnt, [7:0] drop_cnt.
  localparam int EW = 21;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_v   [4];
  logic       start_v [4];
  logic       a_w     [4];
  logic       b_w     [4];
  logic       busy_w  [4];
  logic [7:0] rsp_w   [4];
  logic [7:0] drop_w  [4];
  state_t     st_w    [4];
  logic [1:0] rsp3, drop3;

  // inst0: defaults
  start_rsp_driver u_dut0 (
    .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .a(a_w[0]), .b(b_w[0]),
    .busy(busy_w[0]), .rsp_cnt(rsp_w[0]), .drop_cnt(drop_w[0]), .dbg_state(st_w[0])
  );
  // inst1: DELAY=3, HOLD=2
  start_rsp_driver #(.DELAY(3), .HOLD(2)) u_dut1 (
    .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .a(a_w[1]), .b(b_w[1]),
    .busy(busy_w[1]), .rsp_cnt(rsp_w[1]), .drop_cnt(drop_w[1]), .dbg_state(st_w[1])
  );
  // inst2: DELAY=1, HOLD=4
  start_rsp_driver #(.DELAY(1), .HOLD(4)) u_dut2 (
    .clk(clk), .rst(rst_v[2]), .start(start_v[2]), .a(a_w[2]), .b(b_w[2]),
    .busy(busy_w[2]), .rsp_cnt(rsp_w[2]), .drop_cnt(drop_w[2]), .dbg_state(st_w[2])
  );
  // inst3: CNT_W=2
  start_rsp_driver #(.CNT_W(2)) u_dut3 (
    .clk(clk), .rst(rst_v[3]), .start(start_v[3]), .a(a_w[3]), .b(b_w[3]),
    .busy(busy_w[3]), .rsp_cnt(rsp3), .drop_cnt(drop3), .dbg_state(st_w[3])
  );
  assign rsp_w[3]  = {6'b0, rsp3};
  assign drop_w[3] = {6'b0, drop3};

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  // Monitor: after each edge, compare every expectation queued for it.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    int idx;
    while (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      idx = int'(e[19:18]);
      checks++;
      if (!e[20]) begin
        if (a_w[idx] !== e[17] || b_w[idx] !== e[17] || busy_w[idx] !== e[16]) begin
          failures++;
          $display("FAIL outputs inst%0d t=%0t got a=%b b=%b busy=%b state=%0d, expected a=b=%b busy=%b",
                   idx, $time, a_w[idx], b_w[idx], busy_w[idx], st_w[idx], e[17], e[16]);
        end
      end else begin
        if (rsp_w[idx] !== e[15:8] || drop_w[idx] !== e[7:0]) begin
          failures++;
          $display("FAIL counters inst%0d t=%0t got rsp_cnt=%0d drop_cnt=%0d, expected rsp_cnt=%0d drop_cnt=%0d",
                   idx, $time, rsp_w[idx], drop_w[idx], e[15:8], e[7:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_out(input int inst, input logic exp_a, input logic exp_busy);
    exp_q.push_back({1'b0, 2'(inst), exp_a, exp_busy, 16'h0000});
  endtask

  task automatic push_cnt(input int inst, input int exp_rsp, input int exp_drop);
    exp_q.push_back({1'b1, 2'(inst), 2'b00, 8'(exp_rsp), 8'(exp_drop)});
  endtask

  // One character per cycle; inputs applied before the edge, expectations
  // describe the outputs after that edge. Counters checked after the last cycle.
  task automatic run_vec(input int inst, input string rst_s, input string start_s,
                         input string a_s, input string busy_s,
                         input int exp_rsp, input int exp_drop);
    for (int i = 0; i < rst_s.len(); i++) begin
      rst_v[inst]   = (rst_s[i] == "1");
      start_v[inst] = (start_s[i] == "1");
      @(posedge clk);
      #1;
      push_out(inst, a_s[i] == "1", busy_s[i] == "1");
    end
    push_cnt(inst, exp_rsp, exp_drop);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 4; i++) begin
      rst_v[i]   = 1'b0;
      start_v[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    // Reset state of every configuration.
    for (int i = 0; i < 4; i++) begin
      push_out(i, 1'b0, 1'b0);
      push_cnt(i, 0, 0);
    end

    // Defaults: 3 reset edges, one-cycle start at edge 4, a=b=1 for one edge.
    run_vec(0, "00011111", "00010000", "00010000", "00010000", 1, 0);
    // Defaults: start held 20 cycles gives a single response.
    run_vec(0, "11111111111111111111111", "11111111111111111111000",
               "10000000000000000000000", "10000000000000000000000", 2, 0);
    // Defaults: start high across reset release counts as one rise.
    run_vec(0, "00111", "11100", "00100", "00100", 1, 0);

    // DELAY=3 HOLD=2: clean response, window two edges long after a two-edge gap.
    run_vec(1, "01111111", "00100000", "00001100", "00111100", 1, 0);
    // DELAY=3 HOLD=2: rises in WAIT and on the DRIVE exit edge are dropped.
    run_vec(1, "11111111", "10101000", "00110000", "11110000", 2, 2);

    // DELAY=1 HOLD=4: reset on the second DRIVE edge aborts the response.
    run_vec(2, "0110", "0100", "0110", "0110", 0, 0);
    // DELAY=1 HOLD=4: fresh rise afterwards gives a full four-edge window.
    run_vec(2, "1111111", "0100000", "0111100", "0111100", 1, 0);

    // CNT_W=2: five accepted responses, rsp_cnt saturates at 3.
    run_vec(3, "01111111111", "01010101010", "01010101010", "01010101010", 3, 0);

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got %0d pending entries, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/start_rsp_driver.md
Name: start_rsp_driver

Overview:
- Responder for the start/a/b handshake: detects a rising edge on start and drives a and b high together after a fixed delay, for a fixed number of cycles.
- Sits on the other end of the start-qualified a&&b checker. With defaults it produces exactly "rise of start implies a&&b sampled high on the next posedge".
- Also reports busy status and saturating response/drop counters for bench visibility.

Parameters:
- DELAY, 1, posedges from the rise-detect edge to the first edge where a&&b is sampled high; legal range >=1.
- HOLD, 1, number of consecutive posedges on which a&&b is sampled high; legal range >=1.
- CNT_W, 8, width of the rsp_cnt and drop_cnt counters.

Ports:
- clk  input  1  clock, all logic on posedge.
- rst  input  1  reset, synchronous, active-low.
- start  input  1  request; only its rising edge is significant.
- a  output  1  response qualifier A, registered.
- b  output  1  response qualifier B, registered, always equal to a.
- busy  output  1  high while state != IDLE.
- rsp_cnt  output  CNT_W  accepted responses, saturating.
- drop_cnt  output  CNT_W  rises ignored because not IDLE, saturating.

Behaviour:
- Reset (rst==0 at a posedge): state=IDLE, a=b=0, busy=0, rsp_cnt=0, drop_cnt=0, start_q=0, delay/hold counter=0.
  - Reset mid-WAIT or mid-DRIVE aborts the response; a and b are 0 after that edge.
- Rise detection: rise = start & ~start_q. start_q <= start every non-reset edge.
  - start already high when reset releases counts as a rise on the first edge out of reset.
  - start held high for many cycles produces one rise.
- FSM states: IDLE, WAIT, DRIVE. The counter cnt has width clog2(max(DELAY,HOLD))+1.
- IDLE:
  - On rise with DELAY==1: go to DRIVE, cnt=HOLD-1, a=b=1, rsp_cnt++.
  - On rise with DELAY>1: go to WAIT, cnt=DELAY-2.
- WAIT:
  - If cnt==0: go to DRIVE, cnt=HOLD-1, a=b=1, rsp_cnt++.
  - Otherwise cnt--.
- DRIVE:
  - If cnt==0: go to IDLE, a=b=0.
  - Otherwise cnt--, a=b=1.
- Timing contract: rise detected at edge k means a&&b==1 sampled at edges k+DELAY through k+DELAY+HOLD-1, and 0 at edge k+DELAY+HOLD unless a new response has started.
- Drop rule: a rise seen in WAIT or DRIVE is ignored and increments drop_cnt. This includes a rise on the same edge DRIVE exits to IDLE; a new request is accepted only when state==IDLE at that edge.
- Counters saturate at 2^CNT_W-1 and never wrap.
- busy is registered from the next state: busy=1 from the rise edge until the edge that returns to IDLE.

Optional Feature:
- Macro START_RSP_ASSERT_EN.
- Defined: embedded concurrent assertions, clocked on posedge clk and disabled iff !rst:
  - a==b always.
  - In IDLE, a rise implies ##DELAY (a&&b) [*HOLD].
  - drop_cnt changes only when busy.
  - On pass, $info reports the time; on failure, $error.
- Not defined: no assertion code elaborated; RTL behaviour is identical in both cases.

Decomposition:
- Package start_rsp_pkg holds:
  - the state enum typedef (IDLE=2'd0, WAIT=2'd1, DRIVE=2'd2);
  - localparam helpers for counter width.
- One sub-module, rise_det: synchronous active-low reset, registers start_q and outputs rise. It is reused by the driver and by bench monitors.

Test Plan:
- Defaults (DELAY=1, HOLD=1): rst low for 3 edges; start=1 for one cycle at edge 4 → a=b=1 sampled at edge 5 only, 0 at edge 6; rsp_cnt=1, drop_cnt=0.
- DELAY=3, HOLD=2: rise at edge 10 → a&&b sampled 0 at edges 11–12, 1 at edges 13–14, 0 at edge 15; busy high from after edge 10 through edge 14.
- DELAY=3, HOLD=2: second rise at edge 12 (WAIT) and third at edge 14 (DRIVE) → both ignored, drop_cnt=2, rsp_cnt=1, output window unchanged.
- start held high 20 cycles, plus start=1 across reset release → exactly one response per case; rsp_cnt increments by 1 for each.
- DELAY=1, HOLD=4: rst driven low at the 2nd DRIVE edge → a=b=0, busy=0, counters=0 after that edge; a fresh rise afterwards gives a normal response.
- CNT_W=2: 5 accepted responses → rsp_cnt stays at 3. Build with START_RSP_ASSERT_EN: no assertion failures over all the above.
